// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle CPU front end: PC source encodings,
// the halt opcode and the fetch sequencer state encoding.
package cpu_defs_pkg;

   localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_JR     = 2'b11;

   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_READY,
      ST_HALT
   } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: sequential, branch (word offset), J-format
// jump inside the current 256 MB region, and register-indirect jump.
module next_pc_sel
   import cpu_defs_pkg::*;
(
   input  logic [1:0]  pc_src,
   input  logic        branch_take,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] imm_ext,
   input  logic [25:0] jump_target,
   input  logic [31:0] reg_addr,
   output logic [31:0] next_pc
);

   always_comb begin
      next_pc = pc_plus4;
      case (pc_src)
         PC_SRC_PLUS4:  next_pc = pc_plus4;
         PC_SRC_BRANCH: next_pc = branch_take ? (pc_plus4 + {imm_ext[29:0], 2'b00}) : pc_plus4;
         PC_SRC_JUMP:   next_pc = {pc_plus4[31:28], jump_target, 2'b00};
         PC_SRC_JR:     next_pc = reg_addr;
         default:       next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC/IR registers plus the IDLE/FETCH/READY/HALT sequencer.
// Defining FETCH_COUNT_EN adds a saturating fetch_count output.
module pc_fetch_unit
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_LIMIT = 240,
   parameter logic [5:0]  HALT_OP    = OP_HALT
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        fetch_start,
   input  logic        pc_write,
   input  logic [1:0]  pc_src,
   input  logic        branch_take,
   input  logic [31:0] imm_ext,
   input  logic [25:0] jump_target,
   input  logic [31:0] reg_addr,
   output logic [31:0] i_addr,
   input  logic [31:0] i_data,
   output logic [31:0] ir,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        ir_valid,
   output logic        halted,
`ifdef FETCH_COUNT_EN
   output logic [31:0] fetch_count,
`endif
   output logic        fetch_fault
);

   localparam logic [31:0] LIMIT = 32'(IMEM_LIMIT);

   fetch_state_t state, state_next;
   logic [31:0]  next_pc;
   logic         fetch_bad;
   logic         halt_word;

   next_pc_sel u_next_pc_sel (
      .pc_src      (pc_src),
      .branch_take (branch_take),
      .pc_plus4    (pc_plus4),
      .imm_ext     (imm_ext),
      .jump_target (jump_target),
      .reg_addr    (reg_addr),
      .next_pc     (next_pc)
   );

   assign i_addr    = pc;
   assign halted    = (state == ST_HALT);
   // An aligned PC near 2^32 makes pc+3 large, not small, so the 32-bit compare is safe.
   assign fetch_bad = (pc[1:0] != 2'b00) || ((pc + 32'd3) > LIMIT);
   assign halt_word = (i_data[31:26] == HALT_OP);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (fetch_start) state_next = ST_FETCH;
         ST_FETCH: state_next = (fetch_bad || halt_word) ? ST_HALT : ST_READY;
         ST_READY: if (pc_write) state_next = ST_IDLE;
         ST_HALT:  state_next = ST_HALT;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         pc          <= RESET_PC;
         ir          <= '0;
         pc_plus4    <= '0;
         ir_valid    <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (fetch_bad) begin
                  fetch_fault <= 1'b1;
                  ir_valid    <= 1'b0;
               end else begin
                  ir       <= i_data;
                  pc_plus4 <= pc + 32'd4;
                  ir_valid <= 1'b1;
               end
            end
            ST_READY: begin
               if (pc_write) begin
                  pc       <= next_pc;
                  ir_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_COUNT_EN
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
         fetch_count <= '0;
      else if ((state == ST_FETCH) && !fetch_bad && (fetch_count != 32'hFFFF_FFFF))
         fetch_count <= fetch_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with a byte-addressed
// big-endian instruction memory model; expected values are hand-computed.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start, pc_write, branch_take;
   logic [1:0]  pc_src;
   logic [31:0] imm_ext, reg_addr, i_addr, i_data, ir, pc, pc_plus4;
   logic [25:0] jump_target;
   logic        ir_valid, halted, fetch_fault;
`ifdef FETCH_COUNT_EN
   logic [31:0] fetch_count;
`endif

   logic [7:0] mem [0:255];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign i_data = {mem[i_addr[7:0]], mem[i_addr[7:0] + 8'd1],
                    mem[i_addr[7:0] + 8'd2], mem[i_addr[7:0] + 8'd3]};

   pc_fetch_unit dut (
      .CLK         (clk),
      .Reset       (rst),
      .fetch_start (fetch_start),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .branch_take (branch_take),
      .imm_ext     (imm_ext),
      .jump_target (jump_target),
      .reg_addr    (reg_addr),
      .i_addr      (i_addr),
      .i_data      (i_data),
      .ir          (ir),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .ir_valid    (ir_valid),
      .halted      (halted),
`ifdef FETCH_COUNT_EN
      .fetch_count (fetch_count),
`endif
      .fetch_fault (fetch_fault)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic putWord(input int addr, input logic [31:0] w);
      mem[addr]     = w[31:24];
      mem[addr + 1] = w[23:16];
      mem[addr + 2] = w[15:8];
      mem[addr + 3] = w[7:0];
   endtask

   // All steps start and end at a falling edge.
   task automatic applyReset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic doFetch();
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      @(negedge clk);
   endtask

   task automatic doCommit(input logic [1:0] src, input logic take, input logic [31:0] imm,
                           input logic [25:0] jt, input logic [31:0] ra);
      pc_src = src; branch_take = take; imm_ext = imm; jump_target = jt; reg_addr = ra;
      pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      fetch_start = 1'b0; pc_write = 1'b0; pc_src = 2'b00; branch_take = 1'b0;
      imm_ext = '0; jump_target = '0; reg_addr = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      putWord(0,    32'h2001_0005);
      putWord(4,    32'h8C22_0008);
      putWord(8,    32'h0123_4567);
      putWord(16,   32'hAC41_000C);
      putWord(28,   32'h3C01_1234);
      putWord(32,   32'hFC00_0000);
      putWord(64,   32'h0022_1820);
      putWord(236,  32'h8FBF_0010);

      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_pc", pc, 32'h0);
      checkOutput("reset_ir", ir, 32'h0);
      checkOutput("reset_pc4", pc_plus4, 32'h0);
      checkOutput("reset_flags", {29'h0, ir_valid, halted, fetch_fault}, 32'h0);
      rst = 1'b0;
`ifdef FETCH_COUNT_EN
      checkOutput("reset_count", fetch_count, 32'h0);
`endif

      // pc_write while IDLE must be ignored
      doCommit(2'b11, 1'b0, 32'h0, 26'h0, 32'h80);
      checkOutput("idle_pcwrite_ignored", pc, 32'h0);

      doFetch();
      checkOutput("f0_ir", ir, 32'h2001_0005);
      checkOutput("f0_pc4", pc_plus4, 32'h4);
      checkOutput("f0_valid", {31'h0, ir_valid}, 32'h1);
      checkOutput("f0_iaddr", i_addr, 32'h0);

      doCommit(2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
      checkOutput("seq_pc", pc, 32'h4);
      checkOutput("seq_valid", {31'h0, ir_valid}, 32'h0);

      doFetch();
      checkOutput("f4_ir", ir, 32'h8C22_0008);
      checkOutput("f4_pc4", pc_plus4, 32'h8);
      doCommit(2'b01, 1'b1, 32'hFFFF_FFFF, 26'h0, 32'h0);
      checkOutput("branch_taken_pc", pc, 32'h4);

      doFetch();
      doCommit(2'b01, 1'b0, 32'hFFFF_FFFF, 26'h0, 32'h0);
      checkOutput("branch_not_taken_pc", pc, 32'h8);

      doFetch();
      checkOutput("f8_ir", ir, 32'h0123_4567);
      doCommit(2'b11, 1'b0, 32'h0, 26'h0, 32'h10);
      checkOutput("jr_pc", pc, 32'h10);

      doFetch();
      checkOutput("f10_pc4", pc_plus4, 32'h14);
      doCommit(2'b10, 1'b0, 32'h0, 26'h000_0010, 32'h0);
      checkOutput("jump_pc", pc, 32'h40);

      doFetch();
      checkOutput("f40_ir", ir, 32'h0022_1820);
      // fetch_start together with pc_write in READY commits the PC only
      fetch_start = 1'b1;
      doCommit(2'b11, 1'b0, 32'h0, 26'h0, 32'h1C);
      fetch_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("simul_pc", pc, 32'h1C);
      checkOutput("simul_no_fetch_valid", {31'h0, ir_valid}, 32'h0);
      checkOutput("simul_no_fetch_ir", ir, 32'h0022_1820);

      doFetch();
      checkOutput("f1c_ir", ir, 32'h3C01_1234);
      doCommit(2'b11, 1'b0, 32'h0, 26'h0, 32'h2);
      doFetch();
      checkOutput("misalign_halt", {30'h0, halted, fetch_fault}, 32'h3);
      checkOutput("misalign_ir_kept", ir, 32'h3C01_1234);
      checkOutput("misalign_valid", {31'h0, ir_valid}, 32'h0);
      checkOutput("misalign_pc", pc, 32'h2);

      applyReset();
      doFetch();
      doCommit(2'b11, 1'b0, 32'h0, 26'h0, 32'd236);
      doFetch();
      checkOutput("edge236_ir", ir, 32'h8FBF_0010);
      checkOutput("edge236_pc4", pc_plus4, 32'd240);
      checkOutput("edge236_ok", {30'h0, halted, fetch_fault}, 32'h0);
      doCommit(2'b11, 1'b0, 32'h0, 26'h0, 32'd238);
      doFetch();
      checkOutput("range238_halt", {30'h0, halted, fetch_fault}, 32'h3);
      checkOutput("range238_ir_kept", ir, 32'h8FBF_0010);

      applyReset();
      doFetch();
      doCommit(2'b11, 1'b0, 32'h0, 26'h0, 32'd240);
      doFetch();
      checkOutput("range240_halt", {30'h0, halted, fetch_fault}, 32'h3);
      checkOutput("range240_ir_kept", ir, 32'h2001_0005);

      applyReset();
      doFetch();
      doCommit(2'b11, 1'b0, 32'h0, 26'h0, 32'h20);
      doFetch();
      checkOutput("haltop_ir", ir, 32'hFC00_0000);
      checkOutput("haltop_flags", {30'h0, halted, fetch_fault}, 32'h2);
      checkOutput("haltop_pc4", pc_plus4, 32'h24);
      fetch_start = 1'b1; pc_write = 1'b1; pc_src = 2'b11; reg_addr = 32'h0;
      repeat (3) @(negedge clk);
      fetch_start = 1'b0; pc_write = 1'b0;
      checkOutput("halt_frozen_pc", pc, 32'h20);
      checkOutput("halt_frozen_ir", ir, 32'hFC00_0000);
      checkOutput("halt_frozen_flags", {30'h0, halted, fetch_fault}, 32'h2);

      // Reset asserted in the middle of a FETCH cycle
      applyReset();
      doFetch();
      doCommit(2'b11, 1'b0, 32'h0, 26'h0, 32'h1C);
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("midreset_pc", pc, 32'h0);
      checkOutput("midreset_ir", ir, 32'h0);
      checkOutput("midreset_pc4", pc_plus4, 32'h0);
      checkOutput("midreset_flags", {29'h0, ir_valid, halted, fetch_fault}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      doFetch();
      doCommit(2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
      doFetch();
      doCommit(2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
      doFetch();
      checkOutput("after_reset_ir", ir, 32'h0123_4567);
`ifdef FETCH_COUNT_EN
      checkOutput("fetch_count3", fetch_count, 32'h3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
